// File: rtl/axi_slv_pkg.sv
// Shared types for the AXI4 DDR stand-in slave: burst kinds, response codes, engine states.
package axi_slv_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LAT,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_ddr_slv_model_if.sv
// AXI4 write/read channel bundle between a master and the DDR stand-in slave.
interface axi_ddr_slv_model_if #(
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]     awid;
  logic [31:0]             awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid, awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast, wvalid, wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid, bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [31:0]             araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid, arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast, rvalid, rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_slv_ram.sv
// Simple dual-port RAM with byte write enables and a registered, read-first read port.
module axi_slv_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int AW         = 12
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [AW-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [2**AW];

  // Read and write share one edge, so a same-word read returns the pre-write contents.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_ddr_slv_model.sv
// AXI4 slave backed by on-chip RAM, one outstanding burst per direction.
// Optional macro AXI_SLV_RDLAT_EN inserts RD_LAT extra cycles (RD_LAT >= 1) before the first read beat.
module axi_ddr_slv_model
  import axi_slv_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int DATA_WIDTH = 64,
  parameter int MEM_AW     = 12,
  parameter int RD_LAT     = 8
) (
  input  logic               aclk,
  input  logic               areset,
  axi_ddr_slv_model_if.slave s_axi
);

  localparam int OFF = $clog2(DATA_WIDTH/8);

  function automatic logic [MEM_AW-1:0] word_index(input logic [31:0] addr);
    return addr[OFF +: MEM_AW];
  endfunction

  function automatic logic [MEM_AW-1:0] next_index(input logic [MEM_AW-1:0] idx, input logic fixed);
    return fixed ? idx : idx + MEM_AW'(1);
  endfunction

  logic unused_inputs;
  assign unused_inputs = ^{s_axi.awsize, s_axi.arsize, s_axi.awaddr, s_axi.araddr};

  // ---------------- write engine
  wr_state_t             wr_state;
  logic                  awready_q, wready_q, bvalid_q, wr_err, wr_fixed;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [MEM_AW-1:0]     wr_idx;
  logic [7:0]            wr_len, wr_cnt;
  logic                  aw_hs, w_hs, w_last_beat, w_err_nxt;

  assign aw_hs       = s_axi.awvalid && awready_q;
  assign w_hs        = s_axi.wvalid && wready_q;
  assign w_last_beat = (wr_cnt == wr_len);
  assign w_err_nxt   = wr_err | (s_axi.wlast != w_last_beat);

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      wr_err    <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: if (aw_hs) begin
          bid_q     <= s_axi.awid;
          wr_idx    <= word_index(s_axi.awaddr);
          wr_len    <= s_axi.awlen;
          wr_fixed  <= (s_axi.awburst == BURST_FIXED);
          wr_cnt    <= 8'd0;
          wr_err    <= 1'b0;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          wr_state  <= W_DATA;
        end
        // Beat count alone closes the burst; wlast only feeds the error flag.
        W_DATA: if (w_hs) begin
          wr_idx <= next_index(wr_idx, wr_fixed);
          wr_cnt <= wr_cnt + 8'd1;
          wr_err <= w_err_nxt;
          if (w_last_beat) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= w_err_nxt ? RESP_SLVERR : RESP_OKAY;
            wr_state <= W_RESP;
          end
        end
        W_RESP: if (s_axi.bready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wr_state  <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.bid     = bid_q;

  // ---------------- read engine
  rd_state_t             rd_state;
  logic                  arready_q, rd_fixed, infl, infl_last, wp, rp;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [MEM_AW-1:0]     rd_idx, ram_raddr;
  logic [8:0]            iss_left;
  logic [1:0]            occ;
  logic [2:0]            occ_after;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  ar_hs, pop, rvalid_w, rd_active, iss_ar, iss_data, ram_re, iss_last;

  assign ar_hs     = s_axi.arvalid && arready_q;
  assign rvalid_w  = (occ != 2'd0);
  assign pop       = rvalid_w && s_axi.rready;
  assign occ_after = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};

`ifdef AXI_SLV_RDLAT_EN
  logic [7:0] lat_cnt;
  assign iss_ar    = 1'b0;
  assign rd_active = (rd_state == R_DATA) || (rd_state == R_LAT && lat_cnt == 8'd0);
`else
  localparam int unused_rd_lat = RD_LAT;
  assign iss_ar    = ar_hs;
  assign rd_active = (rd_state == R_DATA);
`endif

  // Issue only if the skid can absorb the beat arriving next cycle even with no pop.
  assign iss_data  = rd_active && (iss_left != 9'd0) && (occ_after <= 3'd1);
  assign ram_re    = iss_ar || iss_data;
  assign ram_raddr = iss_ar ? word_index(s_axi.araddr) : rd_idx;
  assign iss_last  = iss_ar ? (s_axi.arlen == 8'd0) : (iss_left == 9'd1);

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b1;
      rid_q     <= '0;
      occ       <= 2'd0;
      infl      <= 1'b0;
      infl_last <= 1'b0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      iss_left  <= 9'd0;
    end else begin
      infl      <= ram_re;
      infl_last <= iss_last;
      occ       <= occ_after[1:0];
      if (infl) begin
        fifo_data[wp] <= ram_rdata;
        fifo_last[wp] <= infl_last;
        wp            <= ~wp;
      end
      if (pop) rp <= ~rp;
      if (iss_data) begin
        rd_idx   <= next_index(rd_idx, rd_fixed);
        iss_left <= iss_left - 9'd1;
      end
      case (rd_state)
        R_IDLE: if (ar_hs) begin
          rid_q     <= s_axi.arid;
          rd_fixed  <= (s_axi.arburst == BURST_FIXED);
          arready_q <= 1'b0;
`ifdef AXI_SLV_RDLAT_EN
          rd_idx    <= word_index(s_axi.araddr);
          iss_left  <= {1'b0, s_axi.arlen} + 9'd1;
          lat_cnt   <= 8'(RD_LAT - 1);
          rd_state  <= R_LAT;
`else
          rd_idx    <= next_index(word_index(s_axi.araddr), s_axi.arburst == BURST_FIXED);
          iss_left  <= {1'b0, s_axi.arlen};
          rd_state  <= R_DATA;
`endif
        end
`ifdef AXI_SLV_RDLAT_EN
        R_LAT: begin
          if (lat_cnt == 8'd0) rd_state <= R_DATA;
          else                 lat_cnt  <= lat_cnt - 8'd1;
        end
`endif
        R_DATA: if (pop && fifo_last[rp]) begin
          arready_q <= 1'b1;
          rd_state  <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_w;
  assign s_axi.rdata   = fifo_data[rp];
  assign s_axi.rlast   = rvalid_w && fifo_last[rp];
  assign s_axi.rid     = rid_q;
  assign s_axi.rresp   = RESP_OKAY;

  axi_slv_ram #(.DATA_WIDTH(DATA_WIDTH), .AW(MEM_AW)) u_ram (
    .clk   (aclk),
    .we    (w_hs),
    .waddr (wr_idx),
    .wbe   (s_axi.wstrb),
    .wdata (s_axi.wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule
